muldiv_sequencer: RTL

- Multi-cycle sequencer for the multiply and divide operations that the ALU control decodes as OP=101 (mul) and OP=110 (div).
- Runs an iterative shift-add multiply or a restoring divide over WIDTH cycles and holds the result in HI/LO registers.
- Asserts BUSY so the hazard/stall logic can freeze the pipeline.
- Sits beside the single-cycle ALU; mfhi/mflo-style reads come from HI/LO.

---
 rtl/muldiv_sequencer_if.sv | 16 +
 rtl/muldiv_sequencer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer_if.sv
// Request/result bundle between the pipeline and the multi-cycle mul/div sequencer.
// master: pipeline side (issues requests, reads results); slave: the sequencer.
interface muldiv_sequencer_if #(parameter int WIDTH = 32);
    logic             START;
    logic [2:0]       OP;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;
    logic             DIV_ZERO;

    modport master (output START, OP, A, B, input BUSY, DONE, HI, LO, DIV_ZERO);
    modport slave  (input START, OP, A, B, output BUSY, DONE, HI, LO, DIV_ZERO);
endinterface

// File: rtl/muldiv_sequencer.sv
// Multi-cycle multiply (shift-add) / divide (restoring) sequencer with HI/LO result
// registers. One iteration per clock over WIDTH clocks; BUSY stalls the pipeline.
// Optional feature: define MULDIV_SIGNED_EN for two's-complement operands
// (magnitudes iterated on the unsigned core, sign fix-up on the result write).
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic CLK,
    input  logic RST,
    muldiv_sequencer_if.slave bus
);
    localparam int         CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_DIV = 3'b110;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FINISH} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;       // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   opnd;      // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   hi, lo;
    logic               div_zero;

    logic               accept, accept_mul, accept_div, div_by_zero, last_iter;
    logic [WIDTH-1:0]   mag_a, mag_b, dz_lo;
    logic [WIDTH-1:0]   res_hi, res_lo;
    logic [WIDTH:0]     sum, shifted, diff;

    assign accept      = bus.START && (state == IDLE) && (bus.OP == OP_MUL || bus.OP == OP_DIV);
    assign accept_mul  = accept && (bus.OP == OP_MUL);
    assign accept_div  = accept && (bus.OP == OP_DIV);
    assign div_by_zero = accept_div && (bus.B == '0);
    assign last_iter   = (cnt == CNT_W'(WIDTH - 1));

`ifdef MULDIV_SIGNED_EN
    logic sign_a, sign_b;

    assign mag_a = bus.A[WIDTH-1] ? -bus.A : bus.A;
    assign mag_b = bus.B[WIDTH-1] ? -bus.B : bus.B;
    assign dz_lo = bus.A[WIDTH-1] ? WIDTH'(1) : '1;

    // Operand signs latched at accept for the final fix-up.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sign_a <= 1'b0;
            sign_b <= 1'b0;
        end else if (accept) begin
            sign_a <= bus.A[WIDTH-1];
            sign_b <= bus.B[WIDTH-1];
        end
    end
`else
    assign mag_a = bus.A;
    assign mag_b = bus.B;
    assign dz_lo = '1;
`endif

    // One shift-add or restoring-divide iteration on the accumulator.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        acc_step = acc;
        sum      = '0;
        shifted  = '0;
        diff     = '0;
        if (state == MUL) begin
            sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
            acc_step = {sum, acc[WIDTH-1:1]};
        end else if (state == DIV) begin
            shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
            diff    = shifted - {1'b0, opnd};
            if (!diff[WIDTH])
                acc_step = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else
                acc_step = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
    end

    // Result as written to HI/LO on the last iteration (sign-corrected when signed).
    always_comb begin
        res_hi = acc_step[2*WIDTH-1:WIDTH];
        res_lo = acc_step[WIDTH-1:0];
`ifdef MULDIV_SIGNED_EN
        if (state == MUL && (sign_a ^ sign_b)) begin
            {res_hi, res_lo} = -acc_step;
        end else if (state == DIV) begin
            if (sign_a ^ sign_b) res_lo = -acc_step[WIDTH-1:0];
            if (sign_a)          res_hi = -acc_step[2*WIDTH-1:WIDTH];
        end
`endif
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept_mul)       state_nxt = MUL;
                else if (div_by_zero) state_nxt = FINISH;
                else if (accept_div)  state_nxt = DIV;
            end
            MUL, DIV: if (last_iter) state_nxt = FINISH;
            FINISH:   state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Operand capture, iteration and HI/LO/DIV_ZERO update.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            hi       <= '0;
            lo       <= '0;
            div_zero <= 1'b0;
        end else if (accept) begin
            cnt      <= '0;
            div_zero <= div_by_zero;
            if (accept_mul) begin
                acc  <= {{WIDTH{1'b0}}, mag_b};
                opnd <= mag_a;
            end else begin
                acc  <= {{WIDTH{1'b0}}, mag_a};
                opnd <= mag_b;
            end
            if (div_by_zero) begin
                hi <= bus.A;
                lo <= dz_lo;
            end
        end else if (state == MUL || state == DIV) begin
            acc <= acc_step;
            cnt <= cnt + 1'b1;
            if (last_iter) begin
                hi <= res_hi;
                lo <= res_lo;
            end
        end
    end

    assign bus.BUSY     = (state == MUL) || (state == DIV);
    assign bus.DONE     = (state == FINISH);
    assign bus.HI       = hi;
    assign bus.LO       = lo;
    assign bus.DIV_ZERO = div_zero;
endmodule
